pipe_result_drain: RTL and testbench
====================================

// Module: pipe_result_drain
// PURPOSE
//  Downstream consumer of the 8-stage compute Pipeline (DEPTH Stage instances plus final x2 register).
//  The Pipeline carries no valid signal. This block keeps a shadow valid shift register aligned to the
//  Pipeline latency, captures each valid result into a small FIFO drained by valid/ready, and flags the
//  first result equal to MATCH, recording the cycle at which it appeared.
// PARAMETERS
//  WIDTH       8    data width of Pipeline output
//  LATENCY     9    cycles from Pipeline input sample to output sample (DEPTH+1); must be >= 1
//  FIFO_DEPTH  4    result FIFO entries; power of 2, >= 2
//  MATCH       160  result value that triggers the match flag
// PORTS
//  clk          in   1              single clock, all state on posedge
//  rst          in   1              synchronous, active-high reset
//  in_valid     in   1              high in the cycle the upstream Pipeline input is meaningful
//  in_data      in   WIDTH          Pipeline output (its out port)
//  arm          in   1              re-arm the match detector (1-cycle pulse)
//  out_data     out  WIDTH          FIFO head
//  out_valid    out  1              FIFO non-empty
//  out_ready    in   1              consumer accepts head this cycle
//  level        out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
//  overflow     out  1              sticky: a valid result was dropped
//  match        out  1              sticky until arm/rst: MATCH result seen
//  match_cycle  out  16             value of cyc at the edge the match was captured
// BEHAVIOUR
//  Reset (rst sampled high): tag_sr, FIFO pointers, level, cyc, overflow, match, match_cycle all 0;
//    state=ARMED; out_valid=0; out_data=0. Reset mid-stream discards all in-flight tags (no stale pushes).
//  cyc: 16-bit free-running count of edges since reset, saturates at 16'hFFFF.
//  Alignment: tag_sr[LATENCY-1:0] shifts in in_valid each edge. s_valid = tag_sr[LATENCY-1].
//    in_valid high at edge k => in_data is sampled at edge k+LATENCY.
//  States: ARMED (capture + compare), HIT (capture frozen; FIFO still drains).
//    ARMED & s_valid & in_data==MATCH: push the sample, match<=1, match_cycle<=cyc, ->HIT.
//    ARMED & s_valid & other value: push the sample.
//    HIT: samples ignored (not pushed, no overflow).
//    arm (any state): match<=0, ->ARMED. A sample at that same edge is dropped.
//    Priority: rst > arm > sample.
//  FIFO: show-ahead; out_data = mem[rd_ptr] when out_valid, else 0. pop = out_valid & out_ready.
//    push while full: allowed only if pop at the same edge (level unchanged).
//      Otherwise the sample is dropped and overflow<=1 (sticky until rst).
//    push+pop when empty: push only (out_valid was 0); the head appears the next cycle.
//    Pointers wrap modulo FIFO_DEPTH. level updates on the same edge: +push -pop.
//  Widths: compare is WIDTH-bit exact. No arithmetic on data. All outputs registered.
// TESTING
//  1 rst held 2 cycles -> level=0, out_valid=0, match=0, overflow=0, match_cycle=0, cyc=0 after release.
//  2 in_valid at edge 10 only, in_data=8'd37 at edge 19 -> one push, out_data=37, level=1,
//    match=0; in_data at edges 18/20 not captured.
//  3 out_ready=0, in_valid 5 consecutive edges, in_data 1..5 aligned -> FIFO holds 1,2,3,4,
//    level=4, overflow=1; drain with out_ready=1 yields 1,2,3,4 in order.
//  4 FIFO full, out_ready=1 and an aligned sample 9 on the same edge -> level stays 4,
//    overflow stays 0, 9 is the last value drained.
//  5 aligned 160 at an edge where cyc=25 -> match=1, match_cycle=25, state HIT; a later aligned
//    160 is not pushed. arm pulse -> match=0. arm on the same edge as an aligned sample -> sample dropped.
//  6 integration: behind an 8-stage Pipeline fed zeros, with in_valid=1 from the first
//    post-reset edge -> results 0..., then 160 (3x+1 chain: 1,4,13,40,121,108,69,208; x2 mod 256).
//    match asserts; match_cycle=9; rst mid-fill -> no pushes until 9 edges after the next in_valid.

Source files
------------

// File: rtl/pipe_result_drain.sv
// Result drain for the valid-less compute pipeline: re-aligns a shadow valid tag, captures
// aligned results into a show-ahead FIFO and latches the first MATCH result with its cycle.
module pipe_result_drain #(
    parameter int unsigned     WIDTH      = 8,
    parameter int unsigned     LATENCY    = 9,
    parameter int unsigned     FIFO_DEPTH = 4,
    parameter logic [WIDTH-1:0] MATCH     = WIDTH'(160)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [WIDTH-1:0]              in_data,
    input  logic                          arm,
    output logic [WIDTH-1:0]              out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          match,
    output logic [15:0]                   match_cycle
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef enum logic {
        ARMED = 1'b0,
        HIT   = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [LATENCY-1:0] tag_sr;
    logic [WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [15:0]        cyc;

    logic               s_valid_c;
    logic               take_c;
    logic               hit_c;
    logic               pop_c;
    logic               push_c;
    logic               drop_c;
    logic [LVL_W-1:0]   level_after_pop_c;
    logic [LVL_W-1:0]   level_next_c;
    logic [PTR_W-1:0]   rd_ptr_next_c;
    logic [WIDTH-1:0]   head_next_c;

    assign s_valid_c = tag_sr[LATENCY-1];
    assign pop_c     = out_valid & out_ready;

    // Capture/compare FSM; arm wins over an aligned sample on the same edge.
    always_comb begin
        state_next = state;
        take_c     = 1'b0;
        hit_c      = 1'b0;
        if (arm) begin
            state_next = ARMED;
        end else if (state == ARMED && s_valid_c) begin
            take_c = 1'b1;
            if (in_data == MATCH) begin
                hit_c      = 1'b1;
                state_next = HIT;
            end
        end
    end

    // FIFO bookkeeping; a full FIFO still accepts a push when the head leaves on the same edge.
    always_comb begin
        level_after_pop_c = level - LVL_W'(pop_c);
        push_c            = take_c && (level_after_pop_c != LVL_W'(FIFO_DEPTH));
        drop_c            = take_c && !push_c;
        level_next_c      = level_after_pop_c + LVL_W'(push_c);
        rd_ptr_next_c     = rd_ptr + PTR_W'(pop_c);
        if (level_next_c == '0) begin
            head_next_c = '0;
        end else if (level_after_pop_c == '0) begin
            head_next_c = in_data;
        end else begin
            head_next_c = mem[rd_ptr_next_c];
        end
    end

    always_ff @(posedge clk) begin
        if (push_c && !rst) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ARMED;
            tag_sr      <= '0;
            cyc         <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            level       <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            overflow    <= 1'b0;
            match       <= 1'b0;
            match_cycle <= '0;
        end else begin
            state  <= state_next;
            tag_sr <= LATENCY'({tag_sr, in_valid});
            if (cyc != 16'hFFFF) begin
                cyc <= cyc + 16'd1;
            end
            if (arm) begin
                match <= 1'b0;
            end else if (hit_c) begin
                match       <= 1'b1;
                match_cycle <= cyc;
            end
            if (drop_c) begin
                overflow <= 1'b1;
            end
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr    <= rd_ptr_next_c;
            level     <= level_next_c;
            out_valid <= (level_next_c != '0);
            out_data  <= head_next_c;
        end
    end
endmodule

// File: tb/tb_pipe_result_drain.sv
// Bench for pipe_result_drain: directed scenarios then random traffic, all checked against a
// queue-based reference model plus an upstream 3x+1 / x2 pipeline model for integration.
module tb_pipe_result_drain;
    localparam int unsigned LATENCY    = 9;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam logic [7:0]  MATCH      = 8'd160;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        arm;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  level;
    logic        overflow;
    logic        match;
    logic [15:0] match_cycle;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int          e;
    int          due[$];
    logic [7:0]  q[$];
    bit          m_armed;
    bit          m_match;
    bit          m_ovf;
    logic [15:0] m_mc;
    logic [7:0]  pipe [9];
    logic [7:0]  pipe_in;

    always #5 clk = ~clk;

    pipe_result_drain dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .arm(arm),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .level(level),
        .overflow(overflow), .match(match), .match_cycle(match_cycle)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Edge-level behaviour: each valid input is due LATENCY edges later.
    task automatic model_edge();
        bit          pop;
        bit          aligned;
        bit          push;
        logic [15:0] cyc_now;
        pop = (q.size() != 0) && out_ready;
        if (rst) begin
            e = 0; due.delete(); q.delete();
            m_armed = 1'b1; m_match = 1'b0; m_ovf = 1'b0; m_mc = '0;
            return;
        end
        cyc_now = (e > 65535) ? 16'hFFFF : 16'(e);
        aligned = 1'b0;
        if (due.size() != 0 && due[0] == e) begin
            aligned = 1'b1;
            void'(due.pop_front());
        end
        if (in_valid) due.push_back(e + int'(LATENCY));
        push = 1'b0;
        if (arm) begin
            m_armed = 1'b1; m_match = 1'b0;
        end else if (m_armed && aligned) begin
            push = 1'b1;
            if (in_data == MATCH) begin
                m_match = 1'b1; m_mc = cyc_now; m_armed = 1'b0;
            end
        end
        if (pop) void'(q.pop_front());
        if (push) begin
            if (q.size() < int'(FIFO_DEPTH)) q.push_back(in_data);
            else m_ovf = 1'b1;
        end
        e++;
    endtask

    task automatic pipe_edge();
        if (rst) begin
            for (int i = 0; i < 9; i++) pipe[i] = 8'd0;
        end else begin
            pipe[8] = 8'(pipe[7] * 2);
            for (int i = 7; i >= 1; i--) pipe[i] = 8'(pipe[i-1] * 3 + 1);
            pipe[0] = 8'(pipe_in * 3 + 1);
        end
    endtask

    task automatic step();
        model_edge();
        pipe_edge();
        @(posedge clk);
        #1;
        chk("level", 32'(level), 32'(q.size()));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("out_data", 32'(out_data), (q.size() != 0) ? 32'(q[0]) : 32'd0);
        chk("match", 32'(match), 32'(m_match));
        chk("match_cycle", 32'(match_cycle), 32'(m_mc));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; arm = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; arm = 1'b0; out_ready = 1'b0; pipe_in = 8'd0;
        step(); step();
        rst = 1'b0;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_match", 32'(match), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_match_cycle", 32'(match_cycle), 32'd0);

        // Single valid: only the sample exactly LATENCY edges later is captured
        in_valid = 1'b1; in_data = 8'd99; step();
        in_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            in_data = (i == 9) ? 8'd37 : 8'd99;
            step();
        end
        chk("t2_data", 32'(out_data), 32'd37);
        chk("t2_level", 32'(level), 32'd1);
        chk("t2_match", 32'(match), 32'd0);

        // Five aligned samples into a 4-deep FIFO with no consumer
        do_reset();
        for (int i = 0; i < 16; i++) begin
            in_valid = (i < 5);
            in_data  = (i >= 9 && i < 14) ? 8'(i - 8) : 8'd0;
            step();
        end
        chk("t3_level", 32'(level), 32'd4);
        chk("t3_overflow", 32'(overflow), 32'd1);
        out_ready = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t3_drain", 32'(out_data), 32'(i + 1));
            step();
        end
        chk("t3_empty", 32'(out_valid), 32'd0);

        // Push into a full FIFO while the head pops on the same edge
        out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            in_valid  = (i < 5);
            in_data   = (i == 9) ? 8'd11 : (i == 10) ? 8'd12 : (i == 11) ? 8'd13 :
                        (i == 12) ? 8'd14 : (i == 13) ? 8'd9 : 8'd0;
            out_ready = (i == 13);
            step();
        end
        chk("t4_level", 32'(level), 32'd4);
        chk("t4_overflow", 32'(overflow), 32'd0);
        out_ready = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t4_drain", 32'(out_data), (i == 3) ? 32'd9 : 32'(12 + i));
            step();
        end

        // Match at cyc 25, later match ignored, arm drops a coincident sample
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1;
        while (e <= 40) begin
            in_data = (e == 25 || e == 30) ? MATCH : 8'($urandom_range(0, 150));
            step();
        end
        chk("t5_match", 32'(match), 32'd1);
        chk("t5_match_cycle", 32'(match_cycle), 32'd25);
        arm = 1'b1; in_data = MATCH; step();
        arm = 1'b0;
        chk("t5_arm_match", 32'(match), 32'd0);
        chk("t5_arm_drop", 32'(level), 32'd0);
        in_data = 8'd77; out_ready = 1'b0; step();
        chk("t5_rearmed", 32'(out_data), 32'd77);

        // Integration behind the 3x+1 / x2 pipeline fed zeros
        pipe_in = 8'd0; out_ready = 1'b1;
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 14; i++) begin
            in_data = pipe[8];
            step();
        end
        chk("t6_match", 32'(match), 32'd1);
        chk("t6_match_cycle", 32'(match_cycle), 32'd9);

        // Reset mid-fill: old tags vanish, next valid lands 9 edges later
        arm = 1'b1; step(); arm = 1'b0;
        in_data = 8'd55; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) step();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        in_valid = 1'b1; step();
        in_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("t6_no_stale", 32'(level), 32'd0);
        end
        step();
        chk("t6_fresh_push", 32'(level), 32'd1);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            arm       = ($urandom_range(0, 29) == 0);
            in_valid  = $urandom_range(0, 1) == 1;
            in_data   = ($urandom_range(0, 7) == 0) ? MATCH : 8'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
